// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch side of the single-cycle core:
// FSM states, error codes and architectural widths.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    ERR
  } fetch_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Clearable, enabled up-counter with a terminal-count flag at TIMEOUT-1.
// Latency: tc is combinational from the count register.
// Backpressure: none; the owner decides when to clear and count.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches one word per instruction over req/gnt/rvalid.
// Latency: 2 cycles enable-to-inst_valid with zero-wait memory; one instruction per 2 cycles.
// Backpressure: the request is held until imem_gnt; the word is held until advance.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [31:0]        next_pc,
  input  logic               advance,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               inst_valid,
  output logic [31:0]        pc,
  output logic [31:0]        inst_count,
  output logic               err,
  output logic [1:0]         err_code
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        count_q;
  logic               inst_valid_q;
  logic               err_q;
  logic [1:0]         err_code_q, err_code_d;

  logic capture;
  logic commit;
  logic cnt_clear;
  logic cnt_en;
  logic cnt_tc;

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    capture    = 1'b0;
    commit     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
      end
      REQ: begin
        // enable is deliberately not consulted: an issued request is never withdrawn
        if (imem_gnt) begin
          if (imem_rvalid) begin
            capture = 1'b1;
            state_d = VALID;
          end else begin
            cnt_clear = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        // data arriving on the limit cycle takes priority over the timeout
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = VALID;
        end else if (cnt_tc) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      VALID: begin
        if (advance) begin
          commit = 1'b1;
          if (!is_word_aligned(next_pc[1:0])) begin
            err_code_d = ERR_MISALIGN;
            state_d    = ERR;
          end else begin
            state_d = enable ? REQ : IDLE;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      count_q      <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= (state_d == VALID);
      err_q        <= (state_d == ERR);
      err_code_q   <= err_code_d;
      if (capture) instr_q <= imem_rdata;
      // a misaligned target is still committed so it is visible for debug
      if (commit) begin
        pc_q    <= next_pc;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign inst_valid  = inst_valid_q;
  assign inst_count  = count_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-cycle RISC CPU: the producing end of the instruction/PC interface that the control decoder consumes. Holds the architectural PC and fetches one 32-bit word per instruction from instruction memory over a request/grant/response handshake. Presents the word as `instruction` with a valid flag. On `advance`, commits the decoder's `next_pc` (its branch/jump/PC+4 result). Sits between the instruction memory and the control/datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- TIMEOUT, 16, max cycles in WAIT before a fetch timeout error (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  permit new fetches
- next_pc  in  32  next PC from the control decoder
- advance  in  1  core consumed current instruction; commit next_pc
- imem_req  out  1  memory request
- imem_addr  out  32  request address (= pc)
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instruction  out  32  registered instruction word
- inst_valid  out  1  instruction holds a fetched word for pc
- pc  out  32  current PC
- inst_count  out  32  number of committed instructions (advances)
- err  out  1  sticky error
- err_code  out  2  0 none, 1 misaligned next_pc, 2 fetch timeout

## Operation
- States: IDLE, REQ, WAIT, VALID, ERR.
- IDLE: imem_req=0. If enable=1, go to REQ next cycle. imem_rvalid is ignored.
- REQ: imem_req=1, imem_addr=pc, held stable until imem_gnt.
  - gnt=1 with rvalid=0: go to WAIT and clear the timeout counter.
  - gnt=1 and rvalid=1 in the same cycle: capture rdata and go to VALID directly.
  - enable dropping in REQ does not withdraw the request.
- WAIT: imem_req=0; counter increments each cycle.
  - On rvalid: instruction<=imem_rdata, go to VALID.
  - If counter reaches TIMEOUT-1 without rvalid: go to ERR, err_code=2.
  - rvalid on the same cycle as the limit wins; the data is captured.
  - enable=0 does not abort an outstanding fetch.
- VALID: inst_valid=1; instruction and pc are stable.
  - On advance: pc<=next_pc and inst_count<=inst_count+1 (wraps modulo 2^32).
  - If next_pc[1:0]!=0: go to ERR with err_code=1; the misaligned PC is still loaded into pc for debug.
  - Otherwise go to REQ if enable=1, else IDLE.
  - advance outside VALID is ignored.
- ERR: terminal until reset. imem_req=0, inst_valid=0, err=1, and err_code holds its value.
- Stray imem_rvalid in IDLE, REQ (without gnt), VALID or ERR is ignored. rdata is captured only as specified above.

## Timing
- Reset (async assert, synchronous deassert expected from the reset source): state=IDLE, pc=RESET_PC, instruction=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, inst_count=0, err=0, err_code=0, counter=0.
- Reset mid-transaction: all outputs take reset values immediately. A late memory response after reset is dropped (IDLE ignores rvalid).
- Minimum fetch latency: enable rises at cycle 0, REQ at 1. With gnt+rvalid at 1, inst_valid=1 at 2.
- Back-to-back throughput: advance in VALID at cycle n gives REQ at n+1; with zero-wait memory, next inst_valid at n+2. That is one instruction per 2 cycles.
- inst_valid falls on the cycle after advance. instruction is not cleared; it keeps the old word until overwritten.
- imem_addr is driven from the registered pc at all times (no combinational path from next_pc).
- All outputs are registered except imem_req, which decodes directly from state.

## Structure
- Shared package `cpu_pkg`:
  - state typedef (IDLE/REQ/WAIT/VALID/ERR)
  - err_code constants (ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT)
  - RESET_PC default
  - instruction word width 32
- One sub-module: `fetch_timeout_counter`, a clearable, enabled up-counter with a terminal-count flag at TIMEOUT-1.
- PC commit path and inst_count increment stay in the top module.

## Test plan
- Reset then enable=1, memory grants with rvalid in the same cycle, rdata=32'h8000_0001 → inst_valid=1 two cycles after enable, instruction=32'h8000_0001, pc=0.
- Memory with gnt at cycle +1 and rvalid 3 cycles later → inst_valid asserts the cycle after rvalid. imem_addr stays stable while imem_req=1.
- advance with next_pc=32'h0000_0040 → pc=0x40, inst_count=1, next imem_addr=0x40. Repeat 3 times with PC+4 → inst_count=4.
- advance with next_pc=32'h0000_0042 → err=1, err_code=1, no further imem_req until reset.
- Grant, then withhold rvalid for TIMEOUT=16 cycles → err_code=2. rvalid on exactly the 16th cycle instead → captured, no error.
- Assert rst_n=0 while in WAIT, then release; memory then returns rvalid → output is ignored, pc=RESET_PC, inst_valid=0, state IDLE.
